// File: rtl/hub75_column_driver.sv
// HUB75 column-pair driver: shifts three bit-planes per pair and shows each with binary-weighted OE time.
// Define HUB75_PINGPONG_EN to add a second capture buffer so the next pair loads while this one displays.
module hub75_column_driver #(
   parameter int NUM_ROWS  = 64,
   parameter int SCAN_RATE = 32,
   parameter int RGB_RES   = 9,
   parameter int BASE_OE   = 8
) (
   input  logic                                     clk_in,
   input  logic                                     rst_n_in,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]    columns,
   input  logic [$clog2(SCAN_RATE)-1:0]             col_num1,
   input  logic                                     data_valid,
   output logic                                     hub75_ready,
   output logic                                     r0,
   output logic                                     g0,
   output logic                                     b0,
   output logic                                     r1,
   output logic                                     g1,
   output logic                                     b1,
   output logic [$clog2(SCAN_RATE)-1:0]             addr,
   output logic                                     pclk,
   output logic                                     lat,
   output logic                                     oe
);

   localparam int AW = $clog2(SCAN_RATE);
   localparam int RW = $clog2(NUM_ROWS);
   localparam int CW = RGB_RES / 3;
   localparam int SW = $clog2(4 * BASE_OE);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_REQ,
      ST_WAIT,
      ST_SHIFT,
      ST_LATCH,
      ST_SHOW
   } state_t;

   state_t                                  state;
   logic [1:0]                              plane;
   logic [RW-1:0]                           pix;
   logic [SW-1:0]                           show_cnt;
   logic [5:0]                              rgb;
   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   act_pix;
   logic [AW-1:0]                           act_addr;

`ifdef HUB75_PINGPONG_EN
   logic [1:0][1:0][NUM_ROWS-1:0][RGB_RES-1:0] buf_pix;
   logic [1:0][AW-1:0]                         buf_addr;
   logic                                       act;
   logic                                       idle_full;

   assign act_pix  = buf_pix[act];
   assign act_addr = buf_addr[act];
`else
   logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]      buf_pix;
   logic [AW-1:0]                              buf_addr;

   assign act_pix  = buf_pix;
   assign act_addr = buf_addr;
`endif

   assign {r0, g0, b0, r1, g1, b1} = rgb;

   // One bit of each colour channel of a pixel pair, ordered {r0,g0,b0,r1,g1,b1}.
   function automatic logic [5:0] plane_bits(
      input logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] src,
      input logic [RW-1:0]                         idx,
      input logic [1:0]                            pl
   );
      logic [RGB_RES-1:0] up;
      logic [RGB_RES-1:0] lo;
      logic [CW-1:0]      ur, ug, ub, lr, lg, lb;
      up = src[0][idx];
      lo = src[1][idx];
      ur = up[3*CW-1:2*CW];
      ug = up[2*CW-1:CW];
      ub = up[CW-1:0];
      lr = lo[3*CW-1:2*CW];
      lg = lo[2*CW-1:CW];
      lb = lo[CW-1:0];
      return {ur[pl], ug[pl], ub[pl], lr[pl], lg[pl], lb[pl]};
   endfunction

   function automatic logic [SW-1:0] show_len(input logic [1:0] pl);
      case (pl)
         2'd0:    return SW'(BASE_OE - 1);
         2'd1:    return SW'(2 * BASE_OE - 1);
         default: return SW'(4 * BASE_OE - 1);
      endcase
   endfunction

   // Outputs are registered alongside the state, so every branch loads the values the next state presents.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state       <= ST_INIT;
         plane       <= 2'd0;
         pix         <= '0;
         show_cnt    <= '0;
         rgb         <= '0;
         hub75_ready <= 1'b0;
         addr        <= '0;
         pclk        <= 1'b0;
         lat         <= 1'b0;
         oe          <= 1'b1;
         buf_pix     <= '0;
         buf_addr    <= '0;
`ifdef HUB75_PINGPONG_EN
         act         <= 1'b0;
         idle_full   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_INIT: begin
               hub75_ready <= 1'b1;
               state       <= ST_REQ;
            end
            ST_REQ: begin
               hub75_ready <= 1'b0;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
`ifdef HUB75_PINGPONG_EN
               if (idle_full) begin
                  act         <= ~act;
                  idle_full   <= 1'b0;
                  plane       <= 2'd0;
                  pix         <= RW'(NUM_ROWS - 1);
                  pclk        <= 1'b0;
                  rgb         <= plane_bits(buf_pix[~act], RW'(NUM_ROWS - 1), 2'd0);
                  hub75_ready <= 1'b1;
                  state       <= ST_SHIFT;
               end else if (data_valid) begin
                  buf_pix[act]  <= columns;
                  buf_addr[act] <= col_num1;
                  plane         <= 2'd0;
                  pix           <= RW'(NUM_ROWS - 1);
                  pclk          <= 1'b0;
                  rgb           <= plane_bits(columns, RW'(NUM_ROWS - 1), 2'd0);
                  hub75_ready   <= 1'b1;
                  state         <= ST_SHIFT;
               end
`else
               if (data_valid) begin
                  buf_pix  <= columns;
                  buf_addr <= col_num1;
                  plane    <= 2'd0;
                  pix      <= RW'(NUM_ROWS - 1);
                  pclk     <= 1'b0;
                  rgb      <= plane_bits(columns, RW'(NUM_ROWS - 1), 2'd0);
                  state    <= ST_SHIFT;
               end
`endif
            end
            ST_SHIFT: begin
               hub75_ready <= 1'b0;
               if (!pclk) begin
                  pclk <= 1'b1;
               end else if (pix == '0) begin
                  pclk  <= 1'b0;
                  lat   <= 1'b1;
                  addr  <= act_addr;
                  state <= ST_LATCH;
               end else begin
                  pix  <= pix - RW'(1);
                  pclk <= 1'b0;
                  rgb  <= plane_bits(act_pix, pix - RW'(1), plane);
               end
            end
            ST_LATCH: begin
               lat      <= 1'b0;
               oe       <= 1'b0;
               show_cnt <= show_len(plane);
               state    <= ST_SHOW;
            end
            ST_SHOW: begin
               if (show_cnt == '0) begin
                  oe <= 1'b1;
                  if (plane == 2'd2) begin
`ifdef HUB75_PINGPONG_EN
                     if (idle_full) begin
                        act         <= ~act;
                        idle_full   <= 1'b0;
                        plane       <= 2'd0;
                        pix         <= RW'(NUM_ROWS - 1);
                        rgb         <= plane_bits(buf_pix[~act], RW'(NUM_ROWS - 1), 2'd0);
                        hub75_ready <= 1'b1;
                        state       <= ST_SHIFT;
                     end else begin
                        state <= ST_WAIT;
                     end
`else
                     hub75_ready <= 1'b1;
                     state       <= ST_REQ;
`endif
                  end else begin
                     plane <= plane + 2'd1;
                     pix   <= RW'(NUM_ROWS - 1);
                     rgb   <= plane_bits(act_pix, RW'(NUM_ROWS - 1), plane + 2'd1);
                     state <= ST_SHIFT;
                  end
               end else begin
                  show_cnt <= show_cnt - SW'(1);
               end
            end
            default: state <= ST_INIT;
         endcase
`ifdef HUB75_PINGPONG_EN
         // The next pair may arrive any time the current one is on the panel; only one can be held.
         if (data_valid && !idle_full &&
             (state == ST_SHIFT || state == ST_LATCH || state == ST_SHOW)) begin
            buf_pix[~act]  <= columns;
            buf_addr[~act] <= col_num1;
            idle_full      <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_hub75_column_driver.sv
// Directed bench for hub75_column_driver: table of pixel-pair vectors plus reset and stall sequences.
// HUB75_PINGPONG_EN selects the back-to-back pair sequence instead of the single-buffer checks.
module tb_hub75_column_driver;

   localparam int NR  = 64;
   localparam int SR  = 32;
   localparam int RES = 9;
   localparam int BOE = 8;
   localparam int AW  = 5;

   logic                           clk_in = 1'b0;
   logic                           rst_n_in = 1'b1;
   logic [1:0][NR-1:0][RES-1:0]    columns = '0;
   logic [AW-1:0]                  col_num1 = '0;
   logic                           data_valid = 1'b0;
   logic                           hub75_ready;
   logic                           r0, g0, b0, r1, g1, b1;
   logic [AW-1:0]                  addr;
   logic                           pclk, lat, oe;

   int vecCount  = 0;
   int missCount = 0;

   typedef struct {
      logic [8:0]      up;
      logic [8:0]      lo;
      logic [4:0]      cn;
      int              stall;
      bit              lateStrobe;
      logic [2:0][5:0] bits;
   } vec_t;

   vec_t vecs[4];

   hub75_column_driver #(
      .NUM_ROWS(NR), .SCAN_RATE(SR), .RGB_RES(RES), .BASE_OE(BOE)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .columns(columns), .col_num1(col_num1),
      .data_valid(data_valid), .hub75_ready(hub75_ready),
      .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
      .addr(addr), .pclk(pclk), .lat(lat), .oe(oe)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Entered at the falling edge where hub75_ready is seen; returns at the falling edge of the next pulse.
   task automatic applyStimulus(input vec_t v, input int idx);
      int         k, stallBad, bad, run, rises, pl;
      bit         taken;
      logic       prevPclk;
      logic [4:0] prevAddr;
      logic [5:0] firstBits[3];
      int         pclkCnt[3];
      int         oeRuns[3];
      logic [4:0] latAddr[3];
      for (int p = 0; p < 3; p++) begin
         firstBits[p] = '0; pclkCnt[p] = 0; oeRuns[p] = 0; latAddr[p] = '0;
      end
      k = 0; stallBad = 0;
      for (int s = 0; s < v.stall; s++) begin
         @(negedge clk_in); k++;
         if (hub75_ready || !oe) stallBad++;
      end
      checkOutput($sformatf("v%0d_wait_idle", idx), stallBad, 0);
      columns        = '0;
      columns[0][63] = v.up;
      columns[1][63] = v.lo;
      col_num1       = v.cn;
      data_valid     = 1'b1;
      @(negedge clk_in); k++;
      data_valid = 1'b0;
      columns    = '0;
      prevPclk = 1'b0; pl = 0; run = 0; rises = 0; taken = 1'b0; bad = 0; prevAddr = addr;
      while (1'b1) begin
         if (pclk && !prevPclk) begin
            if (!taken && pl < 3) begin
               firstBits[pl] = {r0, g0, b0, r1, g1, b1};
               taken = 1'b1;
            end
            rises++;
         end
         prevPclk = pclk;
         if (lat) begin
            if (pl < 3) begin
               latAddr[pl] = addr;
               pclkCnt[pl] = rises;
            end
            rises = 0;
         end
         if ((lat || addr != prevAddr) && !oe) bad++;
         prevAddr = addr;
         if (!oe) run++;
         else if (run > 0) begin
            if (pl < 3) oeRuns[pl] = run;
            run = 0; pl++; taken = 1'b0;
         end
         if (hub75_ready || k >= v.stall + 700) break;
         if (v.lateStrobe && k == v.stall + 20) begin
            data_valid = 1'b1; columns = '1; col_num1 = ~v.cn;
         end else begin
            data_valid = 1'b0; columns = '0; col_num1 = v.cn;
         end
         @(negedge clk_in); k++;
      end
      for (int p = 0; p < 3; p++) begin
         checkOutput($sformatf("v%0d_bits_p%0d", idx, p), int'(firstBits[p]), int'(v.bits[p]));
         checkOutput($sformatf("v%0d_pclk_p%0d", idx, p), pclkCnt[p], 64);
         checkOutput($sformatf("v%0d_oe_low_p%0d", idx, p), oeRuns[p], BOE << p);
      end
      checkOutput($sformatf("v%0d_lat_addr", idx), int'(latAddr[0]), int'(v.cn));
      checkOutput($sformatf("v%0d_oe_overlap", idx), bad, 0);
      checkOutput($sformatf("v%0d_period", idx), k, 444 + v.stall);
   endtask

   initial begin
      int lowSeen;
      vecs[0] = '{up: 9'h1C0, lo: 9'h000, cn: 5'd5,  stall: 1,    lateStrobe: 1'b0,
                  bits: {6'b100000, 6'b100000, 6'b100000}};
      vecs[1] = '{up: 9'h038, lo: 9'h007, cn: 5'd31, stall: 1,    lateStrobe: 1'b0,
                  bits: {6'b010001, 6'b010001, 6'b010001}};
      vecs[2] = '{up: 9'h151, lo: 9'h0E6, cn: 5'd0,  stall: 1,    lateStrobe: 1'b1,
                  bits: {6'b100011, 6'b010101, 6'b101100}};
      vecs[3] = '{up: 9'h000, lo: 9'h1FF, cn: 5'd17, stall: 1000, lateStrobe: 1'b1,
                  bits: {6'b000111, 6'b000111, 6'b000111}};

      #1 rst_n_in = 1'b0;
      repeat (3) @(negedge clk_in);
      checkOutput("reset_ready", int'(hub75_ready), 0);
      checkOutput("reset_oe", int'(oe), 1);
      checkOutput("reset_pins", int'({addr, pclk, lat, r0, g0, b0, r1, g1, b1}), 0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      checkOutput("release_ready_c1", int'(hub75_ready), 1);
      checkOutput("release_oe_addr", int'({oe, addr}), 32);

`ifndef HUB75_PINGPONG_EN
      for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

      // Reset asserted part-way through the plane 1 display window.
      @(negedge clk_in);
      columns[0][63] = 9'h1C0; col_num1 = 5'd9; data_valid = 1'b1;
      @(negedge clk_in);
      data_valid = 1'b0; columns = '0;
      lowSeen = 0;
      for (int c = 0; c < 400 && lowSeen < 13; c++) begin
         @(negedge clk_in);
         if (!oe) lowSeen++;
      end
      checkOutput("mid_show_reached", lowSeen, 13);
      checkOutput("mid_show_oe_low", int'(oe), 0);
      #2 rst_n_in = 1'b0;
      #1 checkOutput("reset_oe_async", int'(oe), 1);
      @(negedge clk_in);
      checkOutput("mid_reset_pins", int'({hub75_ready, addr, pclk, lat, r0, g0, b0, r1, g1, b1}), 0);
      rst_n_in = 1'b1;
      @(negedge clk_in);
      checkOutput("restart_ready", int'(hub75_ready), 1);
      applyStimulus(vecs[0], 9);
`else
      begin
         int   lastReady;
         int   nPulse;
         logic prevReady;
         int   gaps[4];
         int   bad;
         lastReady = 1; nPulse = 0; prevReady = 1'b1; bad = 0;
         for (int g = 0; g < 4; g++) gaps[g] = 0;
         for (int cyc = 2; cyc < 1400; cyc++) begin
            @(negedge clk_in);
            data_valid = prevReady;
            columns    = prevReady ? '1 : '0;
            prevReady  = hub75_ready;
            if (lat && !oe) bad++;
            if (hub75_ready) begin
               if (nPulse < 4) gaps[nPulse] = cyc - lastReady;
               nPulse++;
               lastReady = cyc;
            end
         end
         data_valid = 1'b0;
         checkOutput("pp_first_gap", gaps[0], 2);
         for (int g = 1; g < 4; g++) checkOutput($sformatf("pp_period_%0d", g), gaps[g], 443);
         checkOutput("pp_oe_overlap", bad, 0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
